// File: rtl/sc_fifo_pkg.sv
// Shared constants, read-mode encodings and the parity helper for sc_fifo.
// The FIFO_PARITY_EN build option uses even_parity() to protect stored words.
package sc_fifo_pkg;

  localparam int SC_FIFO_WIDTH = 64;
  localparam int SC_FIFO_DEPTH = 16;
  localparam int SC_FIFO_PTR   = 4;

  localparam int SC_FIFO_NORMAL    = 0;
  localparam int SC_FIFO_SHOWAHEAD = 1;

  // Widest data word the parity helper accepts; callers zero-extend into it.
  localparam int SC_FIFO_PAR_MAX_W = 1024;

  // The returned bit makes the total count of ones, including the parity bit, even.
  function automatic logic even_parity(input logic [SC_FIFO_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sc_fifo_mem.sv
// DEPTH x W register array for sc_fifo: one write port and one asynchronous read port.
// It has no reset, so stored contents are undefined until they are written.
module sc_fifo_mem
  import sc_fifo_pkg::*;
#(
  parameter int W     = SC_FIFO_WIDTH,
  parameter int DEPTH = SC_FIFO_DEPTH,
  parameter int PTR   = SC_FIFO_PTR
) (
  input  logic           clk,
  input  logic           we,
  input  logic [PTR-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [PTR-1:0] raddr,
  output logic [W-1:0]   rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with normal or show-ahead read, almost thresholds, sticky errors and flush.
// Define FIFO_PARITY_EN to store an even-parity bit per word and report it on par_err.
module sc_fifo
  import sc_fifo_pkg::*;
#(
  parameter int WIDTH     = SC_FIFO_WIDTH,
  parameter int DEPTH     = SC_FIFO_DEPTH,
  parameter int PTR       = SC_FIFO_PTR,
  parameter int SHOWAHEAD = SC_FIFO_NORMAL,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             flush,
  input  logic             clr_err,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  output logic             overflow,
  output logic             underflow,
  output logic             par_err
);

`ifdef FIFO_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  localparam logic [PTR:0] DEPTH_U     = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AFULL_U     = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0] AEMPTY_U    = (PTR+1)'(AEMPTY_TH);
  localparam logic [PTR:0] USEDW_ONE   = (PTR+1)'(1);
  localparam logic [PTR-1:0] PTR_ONE   = PTR'(1);

  logic [PTR-1:0] wr_ptr;
  logic [PTR-1:0] rd_ptr;
  logic [PTR:0]   usedw_q;
  logic           overflow_q;
  logic           underflow_q;
  logic           wr_acc;
  logic           rd_acc;
  logic [MEM_W-1:0] mem_wdata;
  logic [MEM_W-1:0] mem_rdata;
  logic             rd_perr;

  // wren/rden are requests with no separate ready: a request is accepted in a
  // cycle only when the matching status flag (!full / !empty) was already
  // clear at that edge, and nothing is accepted during flush.
  assign wr_acc = wren & ~full  & ~flush;
  assign rd_acc = rden & ~empty & ~flush;

  // All status flags decode from the registered count only.
  assign usedw        = usedw_q;
  assign full         = (usedw_q == DEPTH_U);
  assign empty        = (usedw_q == '0);
  assign almost_full  = (usedw_q >= AFULL_U);
  assign almost_empty = (usedw_q <= AEMPTY_U);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef FIFO_PARITY_EN
  assign mem_wdata = {even_parity(SC_FIFO_PAR_MAX_W'(datain)), datain};
  assign rd_perr   = even_parity(SC_FIFO_PAR_MAX_W'(mem_rdata[WIDTH-1:0])) ^ mem_rdata[WIDTH];
`else
  assign mem_wdata = datain;
  assign rd_perr   = 1'b0;
`endif

  sc_fifo_mem #(
    .W     (MEM_W),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (mem_wdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   usedw_q <= usedw_q + USEDW_ONE;
        2'b01:   usedw_q <= usedw_q - USEDW_ONE;
        default: usedw_q <= usedw_q;
      endcase
    end
  end

  // Sticky errors: a set in the same cycle as clr_err wins; flush leaves them alone.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (!flush && wren && full) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (!flush && rden && empty) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  if (SHOWAHEAD == SC_FIFO_SHOWAHEAD) begin : g_showahead
    assign dataout = empty ? '0 : mem_rdata[WIDTH-1:0];
    assign par_err = ~empty & rd_perr;
  end else begin : g_normal
    logic [WIDTH-1:0] dout_q;
    logic             perr_q;

    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        dout_q <= '0;
        perr_q <= 1'b0;
      end else if (flush) begin
        dout_q <= '0;
        perr_q <= 1'b0;
      end else begin
        if (rd_acc) begin
          dout_q <= mem_rdata[WIDTH-1:0];
        end
        perr_q <= rd_acc & rd_perr;
      end
    end

    assign dataout = dout_q;
    assign par_err = perr_q;
  end

endmodule
